ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
- Command engine between the CPU-facing keyboard interface and ps2_host.
- Issues PS/2 device commands (one opcode, optional argument byte), waits for ACK (0xFA), retries on RESEND (0xFE) or timeout, and waits for BAT (0xAA/0xFC) after reset command 0xFF.
- Non-protocol received bytes (scancodes) are forwarded to the RX queue unchanged.
- Optionally sends 0xFF automatically after reset.

Parameters:
- TIMEOUT_CYCLES, 500000: clk cycles allowed in any wait state before a timeout.
- MAX_RETRY, 3: retries per byte (resend or timeout) before the command fails.
- AUTO_INIT, 1: when 1, issue 0xFF automatically after reset release.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_byte  in  8  opcode
- cmd_has_arg  in  1  argument byte follows opcode
- cmd_arg  in  8  argument byte
- rsp_done  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_done; 1 = failed
- rsp_code  out  8  last byte consumed (ACK, BAT, 0xFC); 0x00 on timeout failure
- tx_data  out  8  byte to ps2_host
- tx_req  out  1  one-cycle transmit request to ps2_host
- tx_ready  in  1  ps2_host transmit-complete pulse
- rx_data  in  8  ps2_host received byte
- rx_ready  in  1  ps2_host receive pulse
- fwd_data  out  8  forwarded byte to RX queue
- fwd_valid  out  1  one-cycle forward pulse

Behaviour:
- All outputs are registered. Reset values: all 0. cmd_ready is 0 during reset.
- After reset, the state is INIT_SEND if AUTO_INIT=1, otherwise IDLE.
- Reset asserted mid-operation aborts immediately; no rsp_done is produced.
- States: IDLE, SEND_CMD, WAIT_TX_CMD, WAIT_ACK_CMD, SEND_ARG, WAIT_TX_ARG, WAIT_ACK_ARG, WAIT_BAT, FINISH. INIT_SEND behaves as SEND_CMD with opcode 0xFF and no argument.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_byte, cmd_has_arg and cmd_arg, clear the retry counter, and go to SEND_CMD.
- SEND_*: tx_data = latched byte and tx_req=1 for exactly one cycle. Next state is WAIT_TX_*. tx_req therefore rises one cycle after acceptance.
- WAIT_TX_*: on tx_ready, clear the timeout counter and go to WAIT_ACK_*. Bytes received in this state are forwarded.
- WAIT_ACK_*, on rx 0xFA:
  - In WAIT_ACK_CMD: go to SEND_ARG if has_arg; else WAIT_BAT if opcode=0xFF; else FINISH (ok).
  - In WAIT_ACK_ARG: go to FINISH (ok).
  - The retry counter is cleared when moving to the argument byte.
- WAIT_ACK_*, on rx 0xFE or timeout:
  - Increment the retry counter.
  - If it is ≤ MAX_RETRY, return to the matching SEND_* state and resend the same byte (an argument resend does not resend the opcode).
  - Otherwise go to FINISH (err).
- WAIT_ACK_*, any other byte is forwarded and does not affect the state.
- WAIT_BAT:
  - rx 0xAA: FINISH ok.
  - rx 0xFC: FINISH err.
  - Timeout: FINISH err with code 0x00. No retry.
  - Any other byte is forwarded.
- FINISH: rsp_done=1 for one cycle with rsp_err and rsp_code, then IDLE. The auto-init completion also pulses rsp_done.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Counts only in WAIT_TX_*, WAIT_ACK_* and WAIT_BAT; reset on every state entry.
  - Expires when count == TIMEOUT_CYCLES-1.
  - A timeout in WAIT_TX_* is handled like a resend.
- Simultaneous events:
  - rx_ready in the same cycle as timeout expiry: the received byte is processed and the timeout is ignored.
  - tx_ready and rx_ready in the same cycle in WAIT_TX_*: the tx transition happens and the byte is forwarded.
- Forwarding: in IDLE, SEND_* and FINISH every rx byte is forwarded, fwd_valid one cycle after rx_ready.
- 0xFA, 0xFE, 0xAA and 0xFC are consumed, not forwarded, only in the wait state that expects them.

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_BAT_OK=8'hAA, PS2_BAT_FAIL=8'hFC, PS2_CMD_RESET=8'hFF, PS2_CMD_LEDS=8'hED;
  - the state enum typedef.
- One sub-module: ps2_timeout_counter (clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Test Plan:
- AUTO_INIT=1: release reset → tx_req with tx_data=0xFF; tx_ready; rx 0xFA, then 0xAA → rsp_done, rsp_err=0, rsp_code=0xAA, cmd_ready=1.
- cmd 0xED with arg 0x02; reply ACK to each byte → exactly two tx_req (0xED, then 0x02); rsp_done ok with code 0xFA; no fwd_valid.
- cmd 0xED arg 0x07; reply 0xFE to the argument once, then ACK → tx sequence ED, 07, 07; result ok.
- cmd 0xF4 (TIMEOUT_CYCLES=100, MAX_RETRY=3); never answer → 4 transmissions of 0xF4, 100 cycles apart after each tx_ready; then rsp_err=1, code 0x00.
- During WAIT_ACK_CMD, rx 0x1C then 0xFA → fwd_valid with fwd_data=0x1C; command completes ok.
- Assert reset_n=0 in WAIT_TX_ARG → all outputs 0 asynchronously; no rsp_done; after release, the INIT sequence restarts.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 protocol constants and sequencer state encoding
//
// Purpose : protocol byte values used by the command sequencer, the FSM state
//           type, and a helper that identifies the states guarded by a timeout.
// Ports   : none (package)

package ps2_pkg;

    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL  = 8'hFC;
    localparam logic [7:0] PS2_CMD_RESET = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS  = 8'hED;

    typedef enum logic [3:0] {
        ST_INIT_SEND,
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_TX_CMD,
        ST_WAIT_ACK_CMD,
        ST_SEND_ARG,
        ST_WAIT_TX_ARG,
        ST_WAIT_ACK_ARG,
        ST_WAIT_BAT,
        ST_FINISH
    } ps2_state_t;

    // States in which the device owes us an event and the timeout runs.
    function automatic logic is_wait_state(input ps2_state_t s);
        logic w_wait;
        w_wait = 1'b0;
        case (s)
            ST_WAIT_TX_CMD, ST_WAIT_ACK_CMD,
            ST_WAIT_TX_ARG, ST_WAIT_ACK_ARG,
            ST_WAIT_BAT: w_wait = 1'b1;
            default:     w_wait = 1'b0;
        endcase
        return w_wait;
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// rtl/ps2_timeout_counter.sv - cycle counter that flags an expired wait window
//
// Purpose : counts clk cycles while enabled; o_expired is high in the cycle
//           where the count reaches TIMEOUT_CYCLES-1, i.e. the last cycle of a
//           TIMEOUT_CYCLES-long window.
// Ports   : clk, reset_n  - clock, asynchronous active-low reset
//           i_clear       - restart the window on the next edge
//           i_enable      - count while high; held at zero while low
//           o_expired     - window exhausted (combinational from the count)

module ps2_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Dropping enable zeroes the count, so entering any wait state from a
    // non-wait state always starts a fresh window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - PS/2 device command engine with ACK/retry/BAT handling
//
// Purpose : sends an opcode and optional argument to ps2_host, waits for ACK,
//           retries on RESEND or timeout, waits for BAT after a reset command,
//           and forwards every non-protocol received byte to the RX queue.
// Ports   : clk, reset_n                    - clock, asynchronous active-low reset
//           cmd_valid/cmd_ready             - command handshake (ready only in IDLE)
//           cmd_byte, cmd_has_arg, cmd_arg  - opcode and optional argument
//           rsp_done, rsp_err, rsp_code     - completion pulse, failure flag, last byte
//           tx_data, tx_req, tx_ready       - transmit path to ps2_host
//           rx_data, rx_ready               - receive path from ps2_host
//           fwd_data, fwd_valid             - forwarded scancodes

module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRY      = 3,
    parameter bit AUTO_INIT      = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       rsp_done,
    output logic       rsp_err,
    output logic [7:0] rsp_code,
    output logic [7:0] tx_data,
    output logic       tx_req,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] fwd_data,
    output logic       fwd_valid
);

    // One extra code point so the counter can hold MAX_RETRY+1 (the failing try).
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam ps2_state_t RESET_STATE = AUTO_INIT ? ST_INIT_SEND : ST_IDLE;

    ps2_state_t    r_state;
    logic [7:0]    r_opcode;
    logic [7:0]    r_arg;
    logic          r_has_arg;
    logic [RW-1:0] r_retry;

    logic          r_cmd_ready;
    logic          r_rsp_done;
    logic          r_rsp_err;
    logic [7:0]    r_rsp_code;
    logic [7:0]    r_tx_data;
    logic          r_tx_req;
    logic [7:0]    r_fwd_data;
    logic          r_fwd_valid;

    logic          w_tmo_expired;
    logic          w_tmo_clear;
    logic          w_tmo_enable;
    logic          w_fwd;
    logic          w_rx_ack;
    logic          w_rx_resend;
    logic          w_rx_bat_ok;
    logic          w_rx_bat_fail;
    logic          w_ack_timeout;
    logic          w_tx_timeout;
    logic [7:0]    w_nack_code;
    logic [RW-1:0] w_retry_next;
    logic          w_retry_ok;

    assign w_rx_ack      = rx_ready && (rx_data == PS2_ACK);
    assign w_rx_resend   = rx_ready && (rx_data == PS2_RESEND);
    assign w_rx_bat_ok   = rx_ready && (rx_data == PS2_BAT_OK);
    assign w_rx_bat_fail = rx_ready && (rx_data == PS2_BAT_FAIL);

    // A byte arriving in the expiry cycle wins; a completed transmit likewise
    // wins over a WAIT_TX expiry.
    assign w_ack_timeout = w_tmo_expired && !rx_ready;
    assign w_tx_timeout  = w_tmo_expired && !tx_ready;

    // Failure code when retries run out: the RESEND byte if that was the last
    // byte consumed, otherwise 0x00 for a timeout.
    assign w_nack_code   = w_rx_resend ? PS2_RESEND : 8'h00;

    assign w_retry_next  = r_retry + 1'b1;
    assign w_retry_ok    = (w_retry_next <= RETRY_LIMIT);

    // Wait-to-wait transitions need an explicit restart; every other entry
    // into a wait state comes from a non-wait state where the counter is idle.
    assign w_tmo_enable  = is_wait_state(r_state);
    assign w_tmo_clear   = (((r_state == ST_WAIT_TX_CMD) || (r_state == ST_WAIT_TX_ARG)) && tx_ready)
                        || ((r_state == ST_WAIT_ACK_CMD) && w_rx_ack);

    ps2_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );

    // Protocol bytes are swallowed only by the wait state expecting them.
    always_comb begin
        w_fwd = 1'b0;
        if (rx_ready) begin
            case (r_state)
                ST_WAIT_ACK_CMD, ST_WAIT_ACK_ARG:
                    w_fwd = (rx_data != PS2_ACK) && (rx_data != PS2_RESEND);
                ST_WAIT_BAT:
                    w_fwd = (rx_data != PS2_BAT_OK) && (rx_data != PS2_BAT_FAIL);
                default:
                    w_fwd = 1'b1;
            endcase
        end
    end

    // tx_req and rsp_done are set on the transition into SEND_* / FINISH so
    // that each pulse coincides with the cycle spent in that state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RESET_STATE;
            r_opcode    <= '0;
            r_arg       <= '0;
            r_has_arg   <= 1'b0;
            r_retry     <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_done  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= '0;
            r_tx_data   <= '0;
            r_tx_req    <= 1'b0;
            r_fwd_data  <= '0;
            r_fwd_valid <= 1'b0;
        end else begin
            r_tx_req    <= 1'b0;
            r_rsp_done  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_fwd_valid <= w_fwd;
            if (w_fwd) begin
                r_fwd_data <= rx_data;
            end

            case (r_state)
                ST_INIT_SEND: begin
                    r_opcode  <= PS2_CMD_RESET;
                    r_has_arg <= 1'b0;
                    r_arg     <= '0;
                    r_retry   <= '0;
                    r_tx_data <= PS2_CMD_RESET;
                    r_tx_req  <= 1'b1;
                    r_state   <= ST_SEND_CMD;
                end

                ST_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_opcode  <= cmd_byte;
                        r_has_arg <= cmd_has_arg;
                        r_arg     <= cmd_arg;
                        r_retry   <= '0;
                        r_tx_data <= cmd_byte;
                        r_tx_req  <= 1'b1;
                        r_state   <= ST_SEND_CMD;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end

                ST_SEND_CMD: r_state <= ST_WAIT_TX_CMD;
                ST_SEND_ARG: r_state <= ST_WAIT_TX_ARG;

                ST_WAIT_TX_CMD: begin
                    if (tx_ready) begin
                        r_state <= ST_WAIT_ACK_CMD;
                    end else if (w_tx_timeout) begin
                        r_retry <= w_retry_next;
                        if (w_retry_ok) begin
                            r_tx_data <= r_opcode;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_SEND_CMD;
                        end else begin
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 1'b1;
                            r_rsp_code <= 8'h00;
                            r_state    <= ST_FINISH;
                        end
                    end
                end

                ST_WAIT_ACK_CMD: begin
                    if (w_rx_ack) begin
                        if (r_has_arg) begin
                            r_retry   <= '0;
                            r_tx_data <= r_arg;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_SEND_ARG;
                        end else if (r_opcode == PS2_CMD_RESET) begin
                            r_state <= ST_WAIT_BAT;
                        end else begin
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 1'b0;
                            r_rsp_code <= PS2_ACK;
                            r_state    <= ST_FINISH;
                        end
                    end else if (w_rx_resend || w_ack_timeout) begin
                        r_retry <= w_retry_next;
                        if (w_retry_ok) begin
                            r_tx_data <= r_opcode;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_SEND_CMD;
                        end else begin
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 1'b1;
                            r_rsp_code <= w_nack_code;
                            r_state    <= ST_FINISH;
                        end
                    end
                end

                ST_WAIT_TX_ARG: begin
                    if (tx_ready) begin
                        r_state <= ST_WAIT_ACK_ARG;
                    end else if (w_tx_timeout) begin
                        r_retry <= w_retry_next;
                        if (w_retry_ok) begin
                            r_tx_data <= r_arg;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_SEND_ARG;
                        end else begin
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 1'b1;
                            r_rsp_code <= 8'h00;
                            r_state    <= ST_FINISH;
                        end
                    end
                end

                ST_WAIT_ACK_ARG: begin
                    if (w_rx_ack) begin
                        r_rsp_done <= 1'b1;
                        r_rsp_err  <= 1'b0;
                        r_rsp_code <= PS2_ACK;
                        r_state    <= ST_FINISH;
                    end else if (w_rx_resend || w_ack_timeout) begin
                        // Only the argument is resent; the opcode was already ACKed.
                        r_retry <= w_retry_next;
                        if (w_retry_ok) begin
                            r_tx_data <= r_arg;
                            r_tx_req  <= 1'b1;
                            r_state   <= ST_SEND_ARG;
                        end else begin
                            r_rsp_done <= 1'b1;
                            r_rsp_err  <= 1'b1;
                            r_rsp_code <= w_nack_code;
                            r_state    <= ST_FINISH;
                        end
                    end
                end

                ST_WAIT_BAT: begin
                    // Self-test can take a long time; a timeout here is final.
                    if (w_rx_bat_ok) begin
                        r_rsp_done <= 1'b1;
                        r_rsp_err  <= 1'b0;
                        r_rsp_code <= PS2_BAT_OK;
                        r_state    <= ST_FINISH;
                    end else if (w_rx_bat_fail) begin
                        r_rsp_done <= 1'b1;
                        r_rsp_err  <= 1'b1;
                        r_rsp_code <= PS2_BAT_FAIL;
                        r_state    <= ST_FINISH;
                    end else if (w_ack_timeout) begin
                        r_rsp_done <= 1'b1;
                        r_rsp_err  <= 1'b1;
                        r_rsp_code <= 8'h00;
                        r_state    <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_done  = r_rsp_done;
    assign rsp_err   = r_rsp_err;
    assign rsp_code  = r_rsp_code;
    assign tx_data   = r_tx_data;
    assign tx_req    = r_tx_req;
    assign fwd_data  = r_fwd_data;
    assign fwd_valid = r_fwd_valid;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - self-checking bench for ps2_cmd_sequencer

module tb_ps2_cmd_sequencer;
    import ps2_pkg::*;

    localparam int TMO  = 100;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_byte = 8'h00;
    logic       cmd_has_arg = 1'b0;
    logic [7:0] cmd_arg = 8'h00;
    logic       rsp_done;
    logic       rsp_err;
    logic [7:0] rsp_code;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] fwd_data;
    logic       fwd_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];
    logic [7:0] fwd_q[$];
    logic [8:0] rsp_q[$];
    int         rdy_cyc[$];

    ps2_cmd_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRY     (MAXR),
        .AUTO_INIT     (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_byte   (cmd_byte),
        .cmd_has_arg(cmd_has_arg),
        .cmd_arg    (cmd_arg),
        .rsp_done   (rsp_done),
        .rsp_err    (rsp_err),
        .rsp_code   (rsp_code),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .fwd_data   (fwd_data),
        .fwd_valid  (fwd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_req) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (fwd_valid) fwd_q.push_back(fwd_data);
        if (rsp_done)  rsp_q.push_back({rsp_err, rsp_code});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_tx_ready();
        tx_ready = 1'b1;
        rdy_cyc.push_back(cyc + 1);
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic wait_tx(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3 * TMO; i++) begin
            if (tx_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Plays the device for one byte: nack refusals (RESEND or silence), then ACK.
    task automatic serve_byte(input int nack, input bit silent, input logic [7:0] scan,
                              output bit ok);
        bit seen;
        ok = 1'b0;
        for (int att = 0; att <= MAXR; att++) begin
            wait_tx(seen);
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL tx_req_wait: got none want tx_req (attempt %0d)", att);
                return;
            end
            tick($urandom_range(1, 4));
            pulse_tx_ready();
            tick($urandom_range(1, 4));
            if (att < nack) begin
                if (!silent) send_rx(PS2_RESEND);
            end else begin
                if (scan != 8'h00) begin
                    send_rx(scan);
                    tick($urandom_range(0, 2));
                end
                send_rx(PS2_ACK);
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_command(input string name, input bit issue, input logic [7:0] op,
                              input bit has_arg, input logic [7:0] arg, input int nack_cmd,
                              input int nack_arg, input bit silent, input logic [7:0] scan,
                              input bit bat_fail);
        logic [7:0] exp_tx[$];
        logic [7:0] exp_fwd[$];
        bit         exp_err;
        logic [7:0] exp_code;
        bit         ok;
        bit         seen;
        int         tx0, fwd0, rsp0, n;
        tx0  = tx_q.size();
        fwd0 = fwd_q.size();
        rsp0 = rsp_q.size();

        // Reference: each byte goes out once plus once per refusal, capped at
        // MAXR+1 sends; exhausting the cap fails with RESEND or 0x00 (silence).
        exp_err  = 1'b0;
        exp_code = PS2_ACK;
        n = (nack_cmd > MAXR) ? MAXR + 1 : nack_cmd + 1;
        for (int i = 0; i < n; i++) exp_tx.push_back(op);
        if (nack_cmd > MAXR) begin
            exp_err  = 1'b1;
            exp_code = silent ? 8'h00 : PS2_RESEND;
        end else begin
            if (scan != 8'h00) exp_fwd.push_back(scan);
            if (has_arg) begin
                n = (nack_arg > MAXR) ? MAXR + 1 : nack_arg + 1;
                for (int i = 0; i < n; i++) exp_tx.push_back(arg);
                if (nack_arg > MAXR) begin
                    exp_err  = 1'b1;
                    exp_code = silent ? 8'h00 : PS2_RESEND;
                end else if (scan != 8'h00) begin
                    exp_fwd.push_back(scan);
                end
            end else if (op == PS2_CMD_RESET) begin
                exp_err  = bat_fail;
                exp_code = bat_fail ? PS2_BAT_FAIL : PS2_BAT_OK;
            end
        end

        if (issue) begin
            seen = 1'b0;
            for (int i = 0; i < 3 * TMO; i++) begin
                if (cmd_ready) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL %s cmd_ready_wait: got 0 want 1", name);
            end
            cmd_byte    = op;
            cmd_has_arg = has_arg;
            cmd_arg     = arg;
            cmd_valid   = 1'b1;
            @(negedge clk);
            cmd_valid   = 1'b0;
        end

        serve_byte(nack_cmd, silent, scan, ok);
        if (ok && has_arg) begin
            serve_byte(nack_arg, silent, scan, ok);
        end else if (ok && op == PS2_CMD_RESET) begin
            tick($urandom_range(1, 4));
            send_rx(bat_fail ? PS2_BAT_FAIL : PS2_BAT_OK);
        end

        seen = 1'b0;
        for (int i = 0; i < 3 * TMO; i++) begin
            if (rsp_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s rsp_done_wait: got none want pulse", name);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s cmd_ready_after: got %b want 1", name, cmd_ready);
        end
        tick(2);

        total++;
        if (tx_q.size() - tx0 != exp_tx.size()) begin
            bad++;
            $display("FAIL %s tx_count: got %0d want %0d", name, tx_q.size() - tx0, exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size() && tx0 + i < tx_q.size(); i++) begin
            total++;
            if (tx_q[tx0 + i] !== exp_tx[i]) begin
                bad++;
                $display("FAIL %s tx_byte[%0d]: got %h want %h", name, i, tx_q[tx0 + i], exp_tx[i]);
            end
        end
        total++;
        if (rsp_q.size() - rsp0 != 1) begin
            bad++;
            $display("FAIL %s rsp_count: got %0d want 1", name, rsp_q.size() - rsp0);
        end else begin
            total++;
            if (rsp_q[rsp0][8] !== exp_err) begin
                bad++;
                $display("FAIL %s rsp_err: got %b want %b", name, rsp_q[rsp0][8], exp_err);
            end
            total++;
            if (rsp_q[rsp0][7:0] !== exp_code) begin
                bad++;
                $display("FAIL %s rsp_code: got %h want %h", name, rsp_q[rsp0][7:0], exp_code);
            end
        end
        total++;
        if (fwd_q.size() - fwd0 != exp_fwd.size()) begin
            bad++;
            $display("FAIL %s fwd_count: got %0d want %0d", name, fwd_q.size() - fwd0, exp_fwd.size());
        end
        for (int i = 0; i < exp_fwd.size() && fwd0 + i < fwd_q.size(); i++) begin
            total++;
            if (fwd_q[fwd0 + i] !== exp_fwd[i]) begin
                bad++;
                $display("FAIL %s fwd_byte[%0d]: got %h want %h", name, i, fwd_q[fwd0 + i], exp_fwd[i]);
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        total++;
        if ({cmd_ready, rsp_done, rsp_err, rsp_code, tx_data, tx_req, fwd_data, fwd_valid} !== 30'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cmd_ready, rsp_done, rsp_err, rsp_code, tx_data, tx_req, fwd_data, fwd_valid});
        end
    endtask

    task automatic test_auto_init();
        reset_n = 1'b1;
        do_command("auto_init", 1'b0, PS2_CMD_RESET, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_leds();
        do_command("leds", 1'b1, PS2_CMD_LEDS, 1'b1, 8'h02, 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_arg_resend();
        do_command("arg_resend", 1'b1, PS2_CMD_LEDS, 1'b1, 8'h07, 0, 1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_retry_limit();
        do_command("retry_edge_ok", 1'b1, 8'hF3, 1'b0, 8'h00, MAXR, 0, 1'b0, 8'h00, 1'b0);
        do_command("retry_exhaust", 1'b1, 8'hF3, 1'b1, 8'h20, 0, MAXR + 1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_timeout();
        int tx0, r0;
        tx0 = tx_q.size();
        r0  = rdy_cyc.size();
        do_command("timeout", 1'b1, 8'hF4, 1'b0, 8'h00, MAXR + 1, 0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < MAXR; i++) begin
            total++;
            if (tx0 + i + 1 >= tx_q.size() || r0 + i >= rdy_cyc.size()) begin
                bad++;
                $display("FAIL timeout_gap[%0d]: got missing event want gap %0d", i, TMO);
            end else if (tx_cyc_q[tx0 + i + 1] - rdy_cyc[r0 + i] != TMO) begin
                bad++;
                $display("FAIL timeout_gap[%0d]: got %0d want %0d", i,
                         tx_cyc_q[tx0 + i + 1] - rdy_cyc[r0 + i], TMO);
            end
        end
    endtask

    task automatic test_scancode_forward();
        do_command("scancode", 1'b1, 8'hF4, 1'b0, 8'h00, 0, 0, 1'b0, 8'h1C, 1'b0);
    endtask

    task automatic test_idle_forward();
        int fwd0;
        fwd0 = fwd_q.size();
        send_rx(PS2_ACK);
        total++;
        if (fwd_valid !== 1'b1 || fwd_data !== PS2_ACK) begin
            bad++;
            $display("FAIL idle_forward: got valid=%b data=%h want valid=1 data=fa", fwd_valid, fwd_data);
        end
        tick(2);
        total++;
        if (fwd_q.size() - fwd0 != 1) begin
            bad++;
            $display("FAIL idle_forward_count: got %0d want 1", fwd_q.size() - fwd0);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok, seen;
        int rsp_before;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_byte    = PS2_CMD_LEDS;
        cmd_has_arg = 1'b1;
        cmd_arg     = 8'h02;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        serve_byte(0, 1'b0, 8'h00, ok);
        wait_tx(seen);
        total++;
        if (!seen || tx_data !== 8'h02) begin
            bad++;
            $display("FAIL midreset_arg_tx: got seen=%b data=%h want seen=1 data=02", seen, tx_data);
        end
        tick(1);
        rsp_before = rsp_q.size();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({cmd_ready, rsp_done, rsp_err, rsp_code, tx_data, tx_req, fwd_data, fwd_valid} !== 30'h0) begin
            bad++;
            $display("FAIL midreset_async_outputs: got %h want 0",
                     {cmd_ready, rsp_done, rsp_err, rsp_code, tx_data, tx_req, fwd_data, fwd_valid});
        end
        tick(3);
        total++;
        if (rsp_q.size() != rsp_before) begin
            bad++;
            $display("FAIL midreset_no_rsp: got %0d want %0d", rsp_q.size(), rsp_before);
        end
        reset_n = 1'b1;
        do_command("reinit", 1'b0, PS2_CMD_RESET, 1'b0, 8'h00, 0, 0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] op, arg, scan;
        bit         has_arg, silent, bat_fail;
        int         nc, na, r;
        for (int k = 0; k < 10; k++) begin
            op = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) op = PS2_CMD_RESET;
            arg      = 8'($urandom_range(0, 255));
            has_arg  = 1'($urandom_range(0, 1));
            silent   = ($urandom_range(0, 3) == 0);
            bat_fail = 1'($urandom_range(0, 1));
            scan     = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 127)) : 8'h00;
            r  = $urandom_range(0, 9);
            nc = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : MAXR + 1;
            r  = $urandom_range(0, 9);
            na = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 3 : MAXR + 1;
            do_command($sformatf("random%0d", k), 1'b1, op, has_arg, arg, nc, na, silent, scan, bat_fail);
        end
    endtask

    initial begin
        test_reset();
        test_auto_init();
        test_leds();
        test_arg_resend();
        test_retry_limit();
        test_timeout();
        test_scancode_forward();
        test_idle_forward();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
